// File: rtl/adc_reader_pkg.sv
// Shared types and elaboration helpers for the serial ADC capture block.
package adc_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StHigh,
    StQuiet
  } state_e;

  // Counter width for a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_legal(input int unsigned clk_div,
                                      input int unsigned frame_bits,
                                      input int unsigned data_bits,
                                      input int unsigned quiet_cycles);
    return (clk_div >= 2) && (frame_bits >= 1) && (data_bits >= 1) &&
           (data_bits <= frame_bits) && (quiet_cycles >= 1);
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: toggles sclk every CLK_DIV cycles while run is high, idles high.
module adc_sclk_gen
  import adc_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic phase_end_o,
  output logic sclk_o
);

  localparam int unsigned CntW = cnt_width(CLK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;

  assign phase_end_o = (cnt_q == CntW'(CLK_DIV - 1));
  assign sclk_o      = sclk_q;

  always_comb begin
    cnt_d  = '0;
    sclk_d = 1'b1;
    if (run_i) begin
      cnt_d  = phase_end_o ? '0 : cnt_q + 1'b1;
      sclk_d = phase_end_o ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/adc_reader.sv
// Serial ADC capture: frames one conversion per trigger edge and returns the low DATA_BITS bits.
module adc_reader
  import adc_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned FRAME_BITS   = 16,
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned QUIET_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trigger,
  input  logic                 sdata,
  output logic                 cs_n,
  output logic                 sclk,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 busy
);

  if (!params_legal(CLK_DIV, FRAME_BITS, DATA_BITS, QUIET_CYCLES)) begin : g_bad_params
    $error("adc_reader: illegal parameter combination");
  end

  localparam int unsigned BitW   = cnt_width(FRAME_BITS + 1);
  localparam int unsigned QuietW = cnt_width(QUIET_CYCLES);

  state_e                 state_q, state_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [QuietW-1:0]      quiet_cnt_q, quiet_cnt_d;
  logic [FRAME_BITS-1:0]  sr_q, sr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   cs_n_q, cs_n_d;
  logic                   busy_q, busy_d;
  logic                   trig_q;
  logic                   sdata_q;

  logic phase_end;
  logic last_bit;
  logic frame_done;
  logic run;
  logic start;

  assign start      = trigger && !trig_q;
  assign last_bit   = (bit_cnt_q == BitW'(FRAME_BITS - 1));
  assign frame_done = (state_q == StHigh) && phase_end && last_bit;
  // Drop run in the final HIGH cycle so sclk returns high without a trailing toggle.
  assign run = ((state_q == StSetup) || (state_q == StLow) || (state_q == StHigh)) && !frame_done;

  adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .run_i      (run),
    .phase_end_o(phase_end),
    .sclk_o     (sclk)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    sr_d        = sr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSetup;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      StSetup: begin
        if (phase_end) state_d = StLow;
      end
      StLow: begin
        if (phase_end) begin
          sr_d    = (sr_q << 1) | FRAME_BITS'(sdata_q);
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (phase_end) begin
          if (last_bit) begin
            state_d     = StQuiet;
            cs_n_d      = 1'b1;
            data_d      = sr_q[DATA_BITS-1:0];
            valid_d     = 1'b1;
            quiet_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = StLow;
          end
        end
      end
      StQuiet: begin
        if (quiet_cnt_q == QuietW'(QUIET_CYCLES - 1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          quiet_cnt_d = quiet_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      quiet_cnt_q <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      trig_q      <= 1'b1;
      sdata_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      trig_q      <= trigger;
      sdata_q     <= sdata;
    end
  end

  assign cs_n  = cs_n_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_adc_reader.sv
// Scoreboard bench for adc_reader: default instance plus a CLK_DIV=2, 16/16-bit instance.
module tb_adc_reader;

  localparam int Quiet = 8;

  typedef struct {
    logic [15:0] data;
    int          cs_low;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigger0, sdata0, cs_n0, sclk0, valid0, busy0;
  logic [11:0] data0;
  logic        trigger1, sdata1, cs_n1, sclk1, valid1, busy1;
  logic [15:0] data1;
  logic [15:0] word0, word1;

  exp_t q0[$];
  exp_t q1[$];
  int   errors;
  int   checks;
  bit   done;

  always #5 clk = ~clk;

  adc_reader u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .trigger(trigger0),
    .sdata  (sdata0),
    .cs_n   (cs_n0),
    .sclk   (sclk0),
    .data   (data0),
    .valid  (valid0),
    .busy   (busy0)
  );

  adc_reader #(
    .CLK_DIV     (2),
    .FRAME_BITS  (16),
    .DATA_BITS   (16),
    .QUIET_CYCLES(8)
  ) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .trigger(trigger1),
    .sdata  (sdata1),
    .cs_n   (cs_n1),
    .sclk   (sclk1),
    .data   (data1),
    .valid  (valid1),
    .busy   (busy1)
  );

  // ADC models: present the next frame bit MSB-first after each sclk fall.
  initial begin
    sdata0 = 1'b0;
    forever begin
      int idx;
      @(negedge cs_n0);
      idx = 15;
      while (cs_n0 == 1'b0 && idx >= 0) begin
        @(negedge sclk0 or posedge cs_n0);
        if (cs_n0 == 1'b0) begin
          sdata0 = word0[idx];
          idx--;
        end
      end
    end
  end

  initial begin
    sdata1 = 1'b0;
    forever begin
      int idx;
      @(negedge cs_n1);
      idx = 15;
      while (cs_n1 == 1'b0 && idx >= 0) begin
        @(negedge sclk1 or posedge cs_n1);
        if (cs_n1 == 1'b0) begin
          sdata1 = word1[idx];
          idx--;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push0(input logic [15:0] d, input int low);
    exp_t e;
    e.data   = d;
    e.cs_low = low;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [15:0] d, input int low);
    exp_t e;
    e.data   = d;
    e.cs_low = low;
    q1.push_back(e);
  endtask

  task automatic monitor();
    int          low_cnt[2];
    int          high_cnt[2];
    bit          seen[2];
    int          ncyc;
    exp_t        e;
    logic [1:0]  csv;
    logic [1:0]  vv;
    logic [15:0] dv[2];
    bit          have;
    ncyc = 0;
    for (int d = 0; d < 2; d++) begin
      low_cnt[d]  = 0;
      high_cnt[d] = 0;
      seen[d]     = 1'b0;
    end
    while (!done) begin
      @(negedge clk);
      ncyc++;
      if (ncyc > 20000) begin
        errors++;
        $display("FAIL watchdog: ran %0d cycles, required under 20000", ncyc);
        $fatal(1, "bench stalled");
      end
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin
          low_cnt[d]  = 0;
          high_cnt[d] = 0;
          seen[d]     = 1'b0;
        end
      end else begin
        csv   = {cs_n1, cs_n0};
        vv    = {valid1, valid0};
        dv[0] = {4'h0, data0};
        dv[1] = data1;
        for (int d = 0; d < 2; d++) begin
          if (vv[d]) begin
            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin
              e    = q0.pop_front();
              have = 1'b1;
            end else if (d == 1 && q1.size() > 0) begin
              e    = q1.pop_front();
              have = 1'b1;
            end
            if (!have) begin
              checks++;
              errors++;
              $display("FAIL unexpected_valid dut%0d: got data 0x%0h, required no valid", d, dv[d]);
            end else begin
              chk($sformatf("data_dut%0d", d), 32'(dv[d]), 32'(e.data));
              chk($sformatf("cs_low_len_dut%0d", d), low_cnt[d], e.cs_low);
              chk($sformatf("cs_n_at_valid_dut%0d", d), 32'(csv[d]), 32'd1);
            end
            low_cnt[d]  = 0;
            high_cnt[d] = 0;
            seen[d]     = 1'b1;
          end
          if (csv[d]) begin
            high_cnt[d]++;
          end else begin
            if (low_cnt[d] == 0 && seen[d]) begin
              checks++;
              if (high_cnt[d] < Quiet) begin
                errors++;
                $display("FAIL quiet_gap dut%0d: cs_n high %0d cycles, required at least %0d",
                         d, high_cnt[d], Quiet);
              end
            end
            low_cnt[d]++;
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    int busy_or_low;
    cycles(3);
    chk("rst_cs_n0", 32'(cs_n0), 32'd1);
    chk("rst_sclk0", 32'(sclk0), 32'd1);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_valid0", 32'(valid0), 32'd0);
    chk("rst_data0", 32'(data0), 32'd0);
    chk("rst_cs_n1", 32'(cs_n1), 32'd1);
    chk("rst_sclk1", 32'(sclk1), 32'd1);
    rst_n = 1'b1;
    cycles(5);

    // Basic capture; trigger stays high past the quiet time and must not retrigger.
    word0 = 16'h0ABC;
    push0(16'h0ABC, 132);
    trigger0 = 1'b1;
    cycles(150);
    trigger0 = 1'b0;
    cycles(10);

    // Back-to-back frames with trigger toggling every 200 cycles.
    word0 = 16'h0FFF;
    push0(16'h0FFF, 132);
    trigger0 = 1'b1;
    cycles(200);
    trigger0 = 1'b0;
    cycles(200);
    word0 = 16'h0001;
    push0(16'h0001, 132);
    trigger0 = 1'b1;
    cycles(200);
    trigger0 = 1'b0;
    cycles(10);

    // Second rising edge 50 cycles into a frame is dropped.
    word0 = 16'h0321;
    push0(16'h0321, 132);
    trigger0 = 1'b1;
    for (int c = 0; c <= 140; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 20) trigger0 = 1'b0;
      if (c == 50) trigger0 = 1'b1;
      if (c == 60) trigger0 = 1'b0;
      if (c == 139) chk("busy_at_140", 32'(busy0), 32'd1);
      if (c == 140) chk("busy_at_141", 32'(busy0), 32'd0);
    end
    cycles(200);

    // Trigger held high through reset release must not start a frame.
    rst_n    = 1'b0;
    trigger0 = 1'b1;
    cycles(2);
    chk("rst_clears_data", 32'(data0), 32'd0);
    rst_n = 1'b1;
    busy_or_low = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!cs_n0 || busy0) busy_or_low++;
    end
    chk("held_trigger_no_frame", busy_or_low, 0);
    trigger0 = 1'b0;
    cycles(2);
    word0 = 16'h0123;
    push0(16'h0123, 132);
    trigger0 = 1'b1;
    cycles(150);
    trigger0 = 1'b0;
    cycles(10);

    // Reset in the LOW phase of bit 7 aborts the frame immediately.
    word0    = 16'h0FAF;
    trigger0 = 1'b1;
    repeat (54) @(posedge clk);
    @(negedge clk);
    chk("mid_sclk_low", 32'(sclk0), 32'd0);
    chk("mid_cs_n_low", 32'(cs_n0), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(cs_n0), 32'd1);
    chk("midrst_sclk", 32'(sclk0), 32'd1);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_data", 32'(data0), 32'd0);
    chk("midrst_valid", 32'(valid0), 32'd0);
    trigger0 = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(5);
    word0 = 16'h0555;
    push0(16'h0555, 132);
    trigger0 = 1'b1;
    cycles(150);
    trigger0 = 1'b0;
    cycles(10);

    // Fast-clock, full-width instance.
    word1 = 16'h8001;
    push1(16'h8001, 66);
    trigger1 = 1'b1;
    cycles(80);
    trigger1 = 1'b0;
    cycles(10);
    done = 1'b1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    done     = 1'b0;
    rst_n    = 1'b0;
    trigger0 = 1'b0;
    trigger1 = 1'b0;
    word0    = 16'h0;
    word1    = 16'h0;
    fork
      monitor();
      stimulus();
    join
    chk("pending_frames_dut0", q0.size(), 0);
    chk("pending_frames_dut1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
